// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - shared state encoding, default widths and width legality check for the FIR tap sequencer
package fir_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } fir_state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_TAPS   = 8;
    localparam int DEF_ACC_W  = 40;

    // The accumulator must hold TAPS full-width products without wrapping.
    function automatic bit acc_w_ok(input int acc_w, input int data_w,
                                    input int coef_w, input int taps);
        return acc_w >= data_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/booth_mac_unit.sv
// rtl/booth_mac_unit.sv - signed radix-4 Booth multiplier feeding a product register and accumulator
module booth_mac_unit #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     mul_en_i,
    input  logic                     acc_clr_i,
    input  logic                     acc_en_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [COEF_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    localparam int BW = COEF_W + (COEF_W % 2);
    localparam int PW = DATA_W + COEF_W;

    logic signed [PW-1:0] a_sx;
    logic signed [BW-1:0] b_sx;
    logic        [BW:0]   b_ext;
    logic        [2:0]    grp;
    logic signed [PW-1:0] pp;
    logic signed [PW-1:0] prod;

    logic signed [ACC_W-1:0] p_q;
    logic                    pv_q;
    logic signed [ACC_W-1:0] acc_q;

    assign a_sx = PW'(a_i);
    assign b_sx = BW'(b_i);

    // Partial sums wrap modulo 2^PW; the final signed product always fits.
    always_comb begin
        b_ext = {b_sx, 1'b0};
        prod  = '0;
        grp   = '0;
        pp    = '0;
        for (int i = 0; i < BW / 2; i++) begin
            grp = b_ext[2*i +: 3];
            case (grp)
                3'b001, 3'b010: pp = a_sx;
                3'b011:         pp = a_sx <<< 1;
                3'b100:         pp = -(a_sx <<< 1);
                3'b101, 3'b110: pp = -a_sx;
                default:        pp = '0;
            endcase
            prod = prod + (pp <<< (2 * i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            pv_q  <= 1'b0;
            acc_q <= '0;
        end else if (clear_i) begin
            p_q   <= '0;
            pv_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            if (mul_en_i) begin
                p_q <= ACC_W'(prod);
            end
            pv_q <= mul_en_i;
            if (acc_clr_i) begin
                acc_q <= '0;
            end else if (acc_en_i && pv_q) begin
                acc_q <= acc_q + p_q;
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/booth_fir_tap_sequencer.sv
// rtl/booth_fir_tap_sequencer.sv - time-multiplexed FIR controller sharing one Booth MAC across all taps
module booth_fir_tap_sequencer
    import fir_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    output logic                       coef_err,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [DATA_W-1:0]   s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [ACC_W-1:0]    m_data,
    output logic                       busy
);

    localparam int KW = $clog2(TAPS);

    if (TAPS < 2 || TAPS > 64) begin : g_taps_check
        $error("TAPS must be within 2..64");
    end
    if (!acc_w_ok(ACC_W, DATA_W, COEF_W, TAPS)) begin : g_acc_check
        $error("ACC_W too narrow for DATA_W+COEF_W+clog2(TAPS)");
    end

    fir_state_e state_q, state_d;

    logic [KW-1:0]            k_q;
    logic signed [DATA_W-1:0] x_q [TAPS];
    logic signed [COEF_W-1:0] h_q [TAPS];
    logic                     coef_err_q;
    logic                     accept;
    logic                     last_tap;
    logic                     mul_en;
    logic                     acc_clr;
    logic                     acc_en;

    assign busy     = (state_q != ST_IDLE);
    assign accept   = s_valid && s_ready;
    assign last_tap = (k_q == KW'(TAPS - 1));
    assign coef_err = coef_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        mul_en  = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready = !clear;
                if (s_valid) begin
                    state_d = ST_MAC;
                    acc_clr = 1'b1;
                end
            end
            ST_MAC: begin
                mul_en = 1'b1;
                acc_en = 1'b1;
                if (last_tap) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                acc_en  = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
        end
    end

    // Coefficients survive clear; only reset zeroes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            coef_err_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                h_q[i] <= '0;
            end
        end else begin
            coef_err_q <= coef_we && busy && !clear;
            if (clear) begin
                k_q <= '0;
                for (int i = 0; i < TAPS; i++) begin
                    x_q[i] <= '0;
                end
            end else begin
                if (accept) begin
                    x_q[0] <= s_data;
                    for (int i = 1; i < TAPS; i++) begin
                        x_q[i] <= x_q[i-1];
                    end
                    k_q <= '0;
                end else if (mul_en) begin
                    k_q <= last_tap ? '0 : k_q + 1'b1;
                end
                if (coef_we && !busy) begin
                    h_q[coef_addr] <= coef_wdata;
                end
            end
        end
    end

    booth_mac_unit #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear),
        .mul_en_i  (mul_en),
        .acc_clr_i (acc_clr),
        .acc_en_i  (acc_en),
        .a_i       (x_q[k_q]),
        .b_i       (h_q[k_q]),
        .acc_o     (m_data)
    );

endmodule
